// File: rtl/axil_status_poller_if.sv
// AXI4-Lite read-channel bundle used by the status poller.
// The master modport is the poller side; the slave modport is the register block side.
interface axil_status_poller_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_status_poller.sv
// AXI4-Lite status-register poller: reads one register until a masked match, limit, error or abort.
// Optional macro POLL_CNT_EN exposes the poll counter on the poll_count port.
module axil_status_poller #(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 'h34,
  parameter logic [DATA_W-1:0] POLL_MASK   = 'h3,
  parameter logic [DATA_W-1:0] POLL_MATCH  = 'h2,
  parameter int unsigned       GAP_CYCLES  = 16,
  parameter int unsigned       MAX_POLLS   = 0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  axil_status_poller_if.master m_axi_lite,
  output logic                 busy,
  output logic                 done,
  output logic                 matched,
  output logic                 timeout,
  output logic                 resp_err,
  output logic [DATA_W-1:0]    status
`ifdef POLL_CNT_EN
  ,
  output logic [CNT_W-1:0]     poll_count
`endif
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StCheck, StGap, StDone} state_e;

`ifdef POLL_CNT_EN
  localparam bit CntUsed = 1'b1;
`else
  localparam bit CntUsed = (MAX_POLLS != 0);
`endif
  localparam logic [CNT_W-1:0] MaxPolls = CNT_W'(MAX_POLLS);
  localparam logic [CNT_W-1:0] GapLoad  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              abort_q, abort_d;
  logic              matched_q, matched_d;
  logic              timeout_q, timeout_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic [1:0]        rresp_q, rresp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      abort_q    <= 1'b0;
      matched_q  <= 1'b0;
      timeout_q  <= 1'b0;
      resp_err_q <= 1'b0;
      status_q   <= '0;
      rresp_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      abort_q    <= abort_d;
      matched_q  <= matched_d;
      timeout_q  <= timeout_d;
      resp_err_q <= resp_err_d;
      status_q   <= status_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    matched_d  = matched_q;
    timeout_d  = timeout_q;
    resp_err_d = resp_err_q;
    status_d   = status_q;
    rresp_d    = rresp_q;
    // Abort is remembered for the whole run; an abort raised alongside start is dropped.
    abort_d    = abort_q | (abort && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (start) begin
          matched_d  = 1'b0;
          timeout_d  = 1'b0;
          resp_err_d = 1'b0;
          poll_cnt_d = '0;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (m_axi_lite.arready) state_d = StData;
      end
      StData: begin
        if (m_axi_lite.rvalid) begin
          status_d = m_axi_lite.rdata;
          rresp_d  = m_axi_lite.rresp;
          if (CntUsed && (poll_cnt_q != '1)) poll_cnt_d = poll_cnt_q + 1'b1;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (rresp_q inside {2'b10, 2'b11}) begin
          resp_err_d = 1'b1;
          state_d    = StDone;
        end else if ((status_q & POLL_MASK) == POLL_MATCH) begin
          matched_d = 1'b1;
          state_d   = StDone;
        end else if (abort_q) begin
          state_d = StDone;
        end else if ((MAX_POLLS != 0) && (poll_cnt_q >= MaxPolls)) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (GAP_CYCLES == 0) begin
          state_d = StAddr;
        end else begin
          gap_cnt_d = GapLoad;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (abort || abort_q) begin
          state_d = StDone;
        end else if (gap_cnt_q == '0) begin
          state_d = StAddr;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StDone: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign m_axi_lite.arvalid = (state_q == StAddr);
  assign m_axi_lite.araddr  = (state_q == StAddr) ? STATUS_ADDR : '0;
  assign m_axi_lite.rready  = (state_q == StData);
  assign busy               = (state_q != StIdle);
  assign done               = (state_q == StDone);
  assign matched            = matched_q;
  assign timeout            = timeout_q;
  assign resp_err           = resp_err_q;
  assign status             = status_q;
`ifdef POLL_CNT_EN
  assign poll_count         = poll_cnt_q;
`endif

endmodule

// File: tb/tb_axil_status_poller.sv
// Randomised and directed bench for axil_status_poller against a cycle-timeline reference model.
module tb_axil_status_poller;
  localparam int G    = 4;
  localparam int MAXP = 5;
  localparam int CW   = 16;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        busy, done, matched, timeout, resp_err;
  logic [31:0] status;
`ifdef POLL_CNT_EN
  logic [CW-1:0] poll_count;
`endif

  axil_status_poller_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  axil_status_poller #(
    .GAP_CYCLES(G),
    .MAX_POLLS (MAXP),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .m_axi_lite(bus),
    .busy      (busy),
    .done      (done),
    .matched   (matched),
    .timeout   (timeout),
    .resp_err  (resp_err),
    .status    (status)
`ifdef POLL_CNT_EN
    ,
    .poll_count(poll_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Slave behaviour: 0 = always ready with fixed data, 1 = random, 2 = arready held off 10 cycles.
  int          mode      = 0;
  logic [31:0] imm_rdata = 32'h0;
  logic [1:0]  imm_rresp = 2'b00;

  initial begin : slave
    bit          hs_ar, hs_r, pend;
    logic [31:0] p_data;
    logic [1:0]  p_resp;
    int          arv_run;
    pend = 0; arv_run = 0; p_data = 0; p_resp = 0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    forever begin
      @(negedge clk);
      hs_ar = bus.arvalid && bus.arready;
      hs_r  = bus.rvalid && bus.rready;
      @(posedge clk);
      #1;
      arv_run = bus.arvalid ? arv_run + 1 : 0;
      if (rst) begin
        pend = 0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
      end else begin
        case (mode)
          1: begin
            if (hs_r) pend = 0;
            if (hs_ar) begin
              pend = 1;
              case ($urandom_range(0, 3))
                0:       p_data = ($urandom & 32'hffff_fffc) | 32'h2;
                1:       p_data = $urandom;
                2:       p_data = 32'h0;
                default: p_data = ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1;
              endcase
              p_resp = {($urandom_range(0, 9) == 0), 1'($urandom)};
            end
            bus.arready = ($urandom_range(0, 2) != 0);
            bus.rvalid  = pend && ($urandom_range(0, 1) == 1);
            bus.rdata   = pend ? p_data : $urandom;
            bus.rresp   = pend ? p_resp : 2'($urandom);
          end
          2: begin
            bus.arready = (arv_run > 10);
            bus.rvalid  = 1'b1;
            bus.rdata   = imm_rdata;
            bus.rresp   = imm_rresp;
          end
          default: begin
            bus.arready = 1'b1;
            bus.rvalid  = 1'b1;
            bus.rdata   = imm_rdata;
            bus.rresp   = imm_rresp;
          end
        endcase
      end
    end
  end

  // Reference model: a timeline of when each bus phase and the done pulse must occur.
  bit           m_run, ar_act, r_act, ab_seen, gap_act;
  bit           p_match, p_to, p_err, m_match, m_to, m_err;
  int           t_arv, t_done, gap_from, gap_until, cyc = 0, nprint = 0;
  logic [CW-1:0] m_polls;
  logic [31:0]  m_status;

  task automatic model_reset();
    m_run = 0; ar_act = 0; r_act = 0; ab_seen = 0; gap_act = 0;
    p_match = 0; p_to = 0; p_err = 0; m_match = 0; m_to = 0; m_err = 0;
    t_arv = -1; t_done = -1; gap_from = -1; gap_until = -1;
    m_polls = '0; m_status = 32'h0;
  endtask

  initial model_reset();

  always @(negedge clk) begin : compare
    bit e_arv, e_rr, e_done, bad;
    cyc++;
    e_arv = 0; e_rr = 0; e_done = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_run && t_arv == cyc) ar_act = 1;
      e_done = m_run && (t_done == cyc);
      if (e_done) begin
        m_match = p_match; m_to = p_to; m_err = p_err;
      end
      e_arv = ar_act;
      e_rr  = r_act;
    end
    bad = (busy !== m_run) || (bus.arvalid !== e_arv) || (bus.rready !== e_rr) ||
          (bus.araddr !== (e_arv ? 10'h34 : 10'h0)) || (done !== e_done) ||
          (matched !== m_match) || (timeout !== m_to) || (resp_err !== m_err) ||
          (status !== m_status);
`ifdef POLL_CNT_EN
    if (poll_count !== m_polls) bad = 1;
`endif
    vectors++;
    if (bad) begin
      miscompares++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL cycle %0d outputs (got/want): busy %b/%b arvalid %b/%b araddr %h/%h rready %b/%b done %b/%b m/t/e %b%b%b/%b%b%b status %h/%h",
                 cyc, busy, m_run, bus.arvalid, e_arv, bus.araddr, e_arv ? 10'h34 : 10'h0,
                 bus.rready, e_rr, done, e_done, matched, timeout, resp_err,
                 m_match, m_to, m_err, status, m_status);
      end
    end
    if (!rst) begin
      if (e_done) begin
        m_run = 0; ab_seen = 0; gap_act = 0; t_done = -1; t_arv = -1;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1; m_match = 0; m_to = 0; m_err = 0;
          p_match = 0; p_to = 0; p_err = 0;
          m_polls = '0; ab_seen = 0; t_arv = cyc + 1;
        end
      end else begin
        if (abort) ab_seen = 1;
        if (gap_act && abort) begin
          // An abort seen in the check cycle is only acted on one cycle later.
          t_done  = (cyc == gap_from) ? cyc + 2 : cyc + 1;
          t_arv   = -1;
          gap_act = 0;
        end else if (gap_act && cyc == gap_until) begin
          gap_act = 0;
        end
        if (e_arv && bus.arready) begin
          ar_act = 0;
          r_act  = 1;
        end
        if (e_rr && bus.rvalid) begin
          r_act    = 0;
          m_status = bus.rdata;
          if (m_polls != '1) m_polls = m_polls + 1'b1;
          if (bus.rresp[1]) begin
            p_err = 1; t_done = cyc + 2;
          end else if ((bus.rdata & 32'h3) == 32'h2) begin
            p_match = 1; t_done = cyc + 2;
          end else if (ab_seen) begin
            t_done = cyc + 2;
          end else if (MAXP != 0 && int'(m_polls) >= MAXP) begin
            p_to = 1; t_done = cyc + 2;
          end else if (G == 0) begin
            t_arv = cyc + 2;
          end else begin
            gap_act = 1; gap_from = cyc + 1; gap_until = cyc + 1 + G; t_arv = cyc + 2 + G;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One run from a start pulse; cycle 0 is the start cycle.
  task automatic run_one(input int abort_at, output int done_cyc, output int ar_cnt,
                         output int first_arv, output logic [9:0] first_addr, output int arv_cyc);
    done_cyc = -1; ar_cnt = 0; first_arv = -1; first_addr = '0; arv_cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (k == abort_at);
      @(negedge clk);
      if (bus.arvalid) begin
        arv_cyc++;
        if (first_arv < 0) begin
          first_arv  = k;
          first_addr = bus.araddr;
        end
      end
      if (bus.arvalid && bus.arready) ar_cnt++;
      if (done) done_cyc = k;
    end
    abort = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      miscompares++;
      $display("FAIL run_one: no done pulse within 200 cycles, got none, want one");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL wait_idle: busy still %b after 500 cycles, want 0", busy);
    end
  endtask

  initial begin : main
    int          dc, ac, fa, vc;
    logic [9:0]  fadr;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset flags", {matched, timeout, resp_err}, 0);
    chk("reset araddr", bus.araddr, 0);
    chk("reset status", status, 0);

    mode = 0; imm_rdata = 32'h2; imm_rresp = 2'b00;
    run_one(0, dc, ac, fa, fadr, vc);
    chk("match first arvalid cycle", fa, 1);
    chk("match araddr", fadr, 10'h34);
    chk("match done cycle", dc, 4);
    chk("match flags", {matched, timeout, resp_err}, 3'b100);
    chk("match status", status, 32'h2);

    imm_rresp = 2'b10;
    run_one(0, dc, ac, fa, fadr, vc);
    chk("slverr done cycle", dc, 4);
    chk("slverr flags", {matched, timeout, resp_err}, 3'b001);
    chk("slverr reads", ac, 1);

    imm_rdata = 32'h1; imm_rresp = 2'b00;
    run_one(0, dc, ac, fa, fadr, vc);
    chk("timeout done cycle", dc, 32);
    chk("timeout reads", ac, MAXP);
    chk("timeout flags", {matched, timeout, resp_err}, 3'b010);
`ifdef POLL_CNT_EN
    chk("timeout poll_count", poll_count, MAXP);
`endif

    mode = 2; imm_rdata = 32'h0;
    run_one(3, dc, ac, fa, fadr, vc);
    chk("abort arvalid cycles", vc, 11);
    chk("abort reads", ac, 1);
    chk("abort done cycle", dc, 14);
    chk("abort flags", {matched, timeout, resp_err}, 3'b000);

    mode = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    wait_idle();

    // Reset while waiting for read data.
    mode = 0; imm_rdata = 32'h2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3;
    chk("data phase rready", bus.rready, 1);
    rst = 1'b1; #1;
    chk("rst in data rready", bus.rready, 0);
    chk("rst in data arvalid", bus.arvalid, 0);
    chk("rst in data busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    run_one(0, dc, ac, fa, fadr, vc);
    chk("after rst match done", dc, 4);
    chk("after rst matched", matched, 1);

    // Reset during the inter-poll gap.
    imm_rdata = 32'h1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("gap phase bus idle", {busy, bus.arvalid, bus.rready}, 3'b100);
    chk("gap phase status", status, 32'h1);
    rst = 1'b1; #1;
    chk("rst in gap busy", busy, 0);
    chk("rst in gap status", status, 0);
    chk("rst in gap flags", {matched, timeout, resp_err, done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    imm_rdata = 32'h2;
    run_one(0, dc, ac, fa, fadr, vc);
    chk("after gap rst done", dc, 4);
    chk("after gap rst matched", matched, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_status_poller.md
Name: axil_status_poller

Overview:
Generalised AXI4-Lite read-side poller for DMA/peripheral status registers. On start, it repeatedly reads one status register until a masked compare matches, a poll limit expires, a slave error returns, or software aborts. It sits between control sequencing logic and the AXI-Lite master port of the DMA register block. It replaces single-shot status checks with a configurable poll loop.

Parameters:
ADDR_W, 10, AXI-Lite address width
DATA_W, 32, AXI-Lite data width
STATUS_ADDR, 'h34, byte address of the polled register
POLL_MASK, 'h3, bits of rdata taking part in the compare
POLL_MATCH, 'h2, required value of (rdata & POLL_MASK)
GAP_CYCLES, 16, idle cycles between polls (0 = back-to-back)
MAX_POLLS, 0, poll limit before timeout (0 = unlimited)
CNT_W, 16, width of the internal poll and gap counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin polling; sampled only in IDLE
abort  in  1  request early termination; latched until the run ends
m_axi_lite_araddr  out  ADDR_W  read address
m_axi_lite_arvalid  out  1  read address valid
m_axi_lite_arready  in  1  read address ready
m_axi_lite_rdata  in  DATA_W  read data
m_axi_lite_rresp  in  2  read response
m_axi_lite_rvalid  in  1  read data valid
m_axi_lite_rready  out  1  read data ready
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at the end of each run
matched  out  1  run ended on compare match; held until next start
timeout  out  1  run ended on poll limit; held until next start
resp_err  out  1  run ended on SLVERR/DECERR; held until next start
status  out  DATA_W  last captured rdata; held until the next capture

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0. araddr = 0. Poll counter, gap counter and abort latch cleared.
  - Reset mid-transaction abandons the transaction. The interconnect shares this reset.
- FSM states: IDLE, ADDR, DATA, CHECK, GAP, DONE.
  - Bus controls decode from the state register: arvalid = (ADDR), rready = (DATA), done = (DONE).
  - araddr = STATUS_ADDR in ADDR, otherwise 0.
- IDLE:
  - start=1 clears matched, timeout and resp_err, clears the poll counter, then -> ADDR.
  - start while busy is ignored.
- ADDR:
  - arvalid held high, with araddr stable, until arready=1 is sampled. Never withdrawn before the handshake, even on abort.
  - On handshake -> DATA.
- DATA:
  - rready=1. On rvalid: capture status <= rdata and store rresp, increment the poll counter (saturating at 2^CNT_W-1), then -> CHECK.
  - rvalid arriving in the same cycle as entry is accepted.
- CHECK (1 cycle). Priority, highest first:
  1. rresp[1]=1 -> resp_err=1, DONE.
  2. (status & POLL_MASK)==POLL_MATCH -> matched=1, DONE.
  3. abort latched -> DONE with no flag set.
  4. MAX_POLLS!=0 and poll count >= MAX_POLLS -> timeout=1, DONE.
  5. Otherwise: GAP with the counter loaded to GAP_CYCLES-1, or ADDR directly if GAP_CYCLES=0.
- GAP:
  - Counter decrements each cycle. At 0 -> ADDR.
  - abort (input or latch) -> DONE immediately.
- DONE:
  - done=1 for one cycle, abort latch cleared, -> IDLE.
- abort:
  - Latches in any non-IDLE state.
  - Ignored in IDLE.
  - Asserted together with start in IDLE: start wins and the latch stays clear.
- Minimum latency with arready, rvalid and match all immediate: start at cycle 0 -> arvalid cycle 1, rready cycle 2, CHECK cycle 3, done cycle 4.

Optional Feature:
- Macro: POLL_CNT_EN.
- Defined:
  - Extra port poll_count out CNT_W, equal to the poll counter.
  - Cleared on start and reset; value held after DONE.
- Undefined:
  - Port absent. The counter exists only when MAX_POLLS!=0, and nothing else changes.

Test Plan:
- Immediate match: STATUS_ADDR='h34, arready/rvalid tie 1, rdata='h2 -> araddr='h34 cycle 1, done pulse cycle 4, matched=1, status='h2.
- Poll loop: rdata='h0 twice then 'h3 (masked 'h3 != 'h2), then 'h2; GAP_CYCLES=4 -> 4 reads, each new arvalid 5 cycles after the previous CHECK, matched=1, poll_count=4 (with POLL_CNT_EN).
- Timeout: MAX_POLLS=3, rdata always 'h1 -> exactly 3 AR handshakes, timeout=1, matched=0, done once.
- Slave error: rresp=2'b10 with rdata='h2 -> resp_err=1, matched=0, done after the first read.
- Abort during ADDR with arready held low 10 cycles -> arvalid stays 1 until arready; read completes, done follows CHECK, no flag set (unless rdata matched: matched=1).
- Async reset asserted in DATA and in GAP -> arvalid, rready, busy and flags read 0 in the same cycle. A new start after release runs normally.
